// File: rtl/prbs_pkg.sv
// Shared PRBS definitions: checker FSM state encoding and the default
// 22-bit LFSR geometry used by both generator and checker.
package prbs_pkg;

  typedef enum logic {
    ST_SEED  = 1'b0,
    ST_CHECK = 1'b1
  } state_t;

  localparam int unsigned PRBS_WIDTH = 22;
  localparam int unsigned PRBS_TAP_A = 21;
  localparam int unsigned PRBS_TAP_B = 20;

endpackage

// File: rtl/prbs_checker_if.sv
// Serial PRBS input and checker status bundle.
interface prbs_checker_if #(
  parameter int unsigned CNT_W = 16
);
  logic             din;
  logic             din_valid;
  logic             locked;
  logic             err_pulse;
  logic [CNT_W-1:0] err_count;
  logic             wrap_tick;

  modport master (
    output din, din_valid,
    input  locked, err_pulse, err_count, wrap_tick
  );

  modport slave (
    input  din, din_valid,
    output locked, err_pulse, err_count, wrap_tick
  );
endinterface

// File: rtl/prbs_next.sv
// One LFSR step: prediction from the current state and the shifted state
// with an externally chosen bit injected at the bottom.
module prbs_next
  import prbs_pkg::*;
#(
  parameter int unsigned WIDTH = PRBS_WIDTH,
  parameter int unsigned TAP_A = PRBS_TAP_A,
  parameter int unsigned TAP_B = PRBS_TAP_B
) (
  input  logic [WIDTH-1:0] state,
  input  logic             in_bit,
  output logic             pred,
  output logic [WIDTH-1:0] next_state
);

  // Feedback of x^WIDTH + x^(WIDTH-1) + 1 and a left shift taking in_bit.
  always_comb begin
    pred       = state[TAP_A] ^ state[TAP_B];
    next_state = {state[WIDTH-2:0], in_bit};
  end

endmodule

// File: rtl/prbs_checker.sv
// PRBS checker: self-seeds from the first WIDTH valid bits, then predicts
// and checks each following bit, counting errors and pattern wraps.
// Optional feature macro: PRBS_CHK_RESYNC_EN (error-rate driven resync).
module prbs_checker
  import prbs_pkg::*;
#(
  parameter int unsigned WIDTH      = PRBS_WIDTH,
  parameter int unsigned TAP_A      = PRBS_TAP_A,
  parameter int unsigned TAP_B      = PRBS_TAP_B,
  parameter int unsigned CNT_W      = 16,
  parameter int unsigned WINDOW     = 256,
  parameter int unsigned ERR_THRESH = 8
) (
  input logic           CCLK,
  input logic           reset,
  prbs_checker_if.slave bus
);

  localparam int unsigned      SEED_W   = $clog2(WIDTH + 1);
  localparam logic [WIDTH-1:0] BIT_LAST = {{(WIDTH-1){1'b1}}, 1'b0};

  if (ERR_THRESH == 0 || ERR_THRESH > WINDOW || WINDOW < 2 ||
      TAP_A >= WIDTH || TAP_B >= WIDTH) begin : g_bad_cfg
    $error("prbs_checker: inconsistent parameter set");
  end

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  lfsr_q, lfsr_d, lfsr_next;
  logic [SEED_W-1:0] seed_cnt_q, seed_cnt_d;
  logic [WIDTH-1:0]  bit_cnt_q, bit_cnt_d;
  logic [CNT_W-1:0]  err_cnt_q, err_cnt_d;
  logic              err_pulse_q, err_pulse_d;
  logic              wrap_q, wrap_d;
  logic              pred, inject, mismatch, seed_done, resync;

  prbs_next #(
    .WIDTH (WIDTH),
    .TAP_A (TAP_A),
    .TAP_B (TAP_B)
  ) u_next (
    .state      (lfsr_q),
    .in_bit     (inject),
    .pred       (pred),
    .next_state (lfsr_next)
  );

  // While checking, the prediction (not din) is shifted in so a bad bit costs exactly one error.
  always_comb begin
    inject    = (state_q == ST_CHECK) ? pred : bus.din;
    mismatch  = bus.din_valid && (state_q == ST_CHECK) && (bus.din != pred);
    seed_done = bus.din_valid && (state_q == ST_SEED) &&
                (seed_cnt_q == SEED_W'(WIDTH - 1));
  end

`ifdef PRBS_CHK_RESYNC_EN
  localparam int unsigned WIN_W  = $clog2(WINDOW);
  localparam int unsigned WERR_W = $clog2(ERR_THRESH + 1);

  logic [WIN_W-1:0]  win_cnt_q, win_cnt_d;
  logic [WERR_W-1:0] win_err_q, win_err_d, win_err_sum;

  // Error-rate window; the threshold test includes the current bit, so the last bit of a window still counts.
  always_comb begin
    win_err_sum = win_err_q + WERR_W'(mismatch);
    resync      = bus.din_valid && (state_q == ST_CHECK) &&
                  (win_err_sum >= WERR_W'(ERR_THRESH));
    win_cnt_d   = win_cnt_q;
    win_err_d   = win_err_q;
    if (resync) begin
      win_cnt_d = '0;
      win_err_d = '0;
    end else if (bus.din_valid && (state_q == ST_CHECK)) begin
      if (win_cnt_q == WIN_W'(WINDOW - 1)) begin
        win_cnt_d = '0;
        win_err_d = '0;
      end else begin
        win_cnt_d = win_cnt_q + WIN_W'(1);
        win_err_d = win_err_sum;
      end
    end
  end

  // Window counter registers.
  always_ff @(posedge CCLK or negedge reset) begin
    if (!reset) begin
      win_cnt_q <= '0;
      win_err_q <= '0;
    end else begin
      win_cnt_q <= win_cnt_d;
      win_err_q <= win_err_d;
    end
  end
`else
  // Without the window logic CHECK is only left through reset.
  always_comb resync = 1'b0;
`endif

  // FSM state register.
  always_ff @(posedge CCLK or negedge reset) begin
    if (!reset) state_q <= ST_SEED;
    else        state_q <= state_d;
  end

  // Next state: lock on a non-zero seed, fall back to seeding on resync.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_SEED:  if (seed_done && (lfsr_next != '0)) state_d = ST_CHECK;
      ST_CHECK: if (resync) state_d = ST_SEED;
      default:  state_d = ST_SEED;
    endcase
  end

  // Datapath next values: shift register, seed/bit counters, error count and pulses.
  always_comb begin
    lfsr_d      = lfsr_q;
    seed_cnt_d  = seed_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    err_cnt_d   = err_cnt_q;
    err_pulse_d = 1'b0;
    wrap_d      = 1'b0;
    if (bus.din_valid) begin
      lfsr_d = lfsr_next;
      if (state_q == ST_SEED) begin
        seed_cnt_d = seed_done ? '0 : seed_cnt_q + SEED_W'(1);
      end else begin
        err_pulse_d = mismatch;
        if (mismatch && (err_cnt_q != '1)) err_cnt_d = err_cnt_q + CNT_W'(1);
        if (bit_cnt_q == BIT_LAST) begin
          bit_cnt_d = '0;
          wrap_d    = 1'b1;
        end else begin
          bit_cnt_d = bit_cnt_q + WIDTH'(1);
        end
        if (resync) begin
          seed_cnt_d = '0;
          bit_cnt_d  = '0;
        end
      end
    end
  end

  // Datapath registers.
  always_ff @(posedge CCLK or negedge reset) begin
    if (!reset) begin
      lfsr_q      <= '0;
      seed_cnt_q  <= '0;
      bit_cnt_q   <= '0;
      err_cnt_q   <= '0;
      err_pulse_q <= 1'b0;
      wrap_q      <= 1'b0;
    end else begin
      lfsr_q      <= lfsr_d;
      seed_cnt_q  <= seed_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      err_cnt_q   <= err_cnt_d;
      err_pulse_q <= err_pulse_d;
      wrap_q      <= wrap_d;
    end
  end

  // Status outputs, all taken straight from registers.
  always_comb begin
    bus.locked    = (state_q == ST_CHECK);
    bus.err_pulse = err_pulse_q;
    bus.err_count = err_cnt_q;
    bus.wrap_tick = wrap_q;
  end

endmodule
